db9_pad_scanner: RTL

Host-side scanner for a physical Mega Drive / Genesis pad on a DB9 port. It drives the TH select line, samples the six pad data lines, and decodes them into per-button pressed flags in the same P_* format the multitap and pad I/O blocks consume. It sits between the external DB9 pins and the controller-emulation blocks: it acts as the console initiating the pad protocol, not the pad answering it.

---
 rtl/db9_pad_scanner.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/db9_pad_scanner.sv
// ---------------------------------------------------------------------------
// db9_pad_scanner
//
// Console-side scanner for a Mega Drive / Genesis pad on a DB9 port. The
// block toggles the TH select line through a fixed phase sequence and samples
// the six pad data lines once per phase. It then publishes the decoded
// buttons as active-high P_* flags, with one VALID pulse per scan.
//
// Optional feature macro: DB9_PAD_SCANNER_SIX_BUTTON_EN
//   defined   : full 8-phase scan with six-button detection and X/Y/Z/MODE
//   undefined : 2-phase scan (phases 0 and 1 only); SIX_BTN and the extra
//               buttons are tied to 0
//
// Parameters
//   SETTLE  CE ticks per phase (TH change to sample), minimum 2
//   IDLE    CE ticks with TH high between scans
//
// Ports
//   CLK       system clock
//   RESET_N   asynchronous active-low reset
//   CE        scan tick enable, one CLK wide; all counters advance on CE
//   ENABLE    scanning allowed (only looked at while idle)
//   PAD_IN    raw DB9 lines, active-low: [0]D0 [1]D1 [2]D2 [3]D3 [4]TL [5]TR
//   PAD_TH    select line to the pad
//   P_*       active-high pressed flags
//   PRESENT   pad detected on the last scan
//   SIX_BTN   six-button pad detected on the last scan
//   VALID     one-CLK pulse when the outputs are refreshed
// ---------------------------------------------------------------------------
module db9_pad_scanner #(
    parameter int SETTLE = 8,
    parameter int IDLE   = 2000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CE,
    input  logic       ENABLE,
    input  logic [5:0] PAD_IN,
    output logic       PAD_TH,
    output logic       P_UP,
    output logic       P_DOWN,
    output logic       P_LEFT,
    output logic       P_RIGHT,
    output logic       P_A,
    output logic       P_B,
    output logic       P_C,
    output logic       P_START,
    output logic       P_MODE,
    output logic       P_X,
    output logic       P_Y,
    output logic       P_Z,
    output logic       PRESENT,
    output logic       SIX_BTN,
    output logic       VALID
);

    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int IDLE_W   = (IDLE > 1) ? $clog2(IDLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(IDLE - 1);

`ifdef DB9_PAD_SCANNER_SIX_BUTTON_EN
    localparam logic [2:0] LAST_PHASE = 3'd7;
`else
    localparam logic [2:0] LAST_PHASE = 3'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PHASE = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    // Synchronizer
    logic [5:0] sync1_q, sync1_d;
    logic [5:0] sync2_q, sync2_d;

    // Sequencer
    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [2:0]          phase_q, phase_d;

    // Registered outputs
    logic       th_q, th_d;
    logic       valid_q, valid_d;
    logic       present_q, present_d;
    logic [7:0] base_q, base_d;          // {START,C,B,A,RIGHT,LEFT,DOWN,UP}

    // Shadows filled during the scan, published in S_LATCH
    logic [7:0] base_sh_q, base_sh_d;
    logic       present_sh_q, present_sh_d;

`ifdef DB9_PAD_SCANNER_SIX_BUTTON_EN
    logic       six_q, six_d;
    logic [3:0] ext_q, ext_d;            // {Z,Y,X,MODE}
    logic       six_sh_q, six_sh_d;
    logic [3:0] ext_sh_q, ext_sh_d;
`endif

    logic       sample_tick;
    logic [5:0] line_low;                // 1 where the synchronized line is low

    assign line_low    = ~sync2_q;
    assign sample_tick = (state_q == S_PHASE) && CE && (settle_cnt_q == SETTLE_LAST);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q      <= 6'b111111;
            sync2_q      <= 6'b111111;
            state_q      <= S_IDLE;
            idle_cnt_q   <= '0;
            settle_cnt_q <= '0;
            phase_q      <= '0;
            th_q         <= 1'b1;
            valid_q      <= 1'b0;
            present_q    <= 1'b0;
            base_q       <= '0;
            base_sh_q    <= '0;
            present_sh_q <= 1'b0;
`ifdef DB9_PAD_SCANNER_SIX_BUTTON_EN
            six_q        <= 1'b0;
            ext_q        <= '0;
            six_sh_q     <= 1'b0;
            ext_sh_q     <= '0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            phase_q      <= phase_d;
            th_q         <= th_d;
            valid_q      <= valid_d;
            present_q    <= present_d;
            base_q       <= base_d;
            base_sh_q    <= base_sh_d;
            present_sh_q <= present_sh_d;
`ifdef DB9_PAD_SCANNER_SIX_BUTTON_EN
            six_q        <= six_d;
            ext_q        <= ext_d;
            six_sh_q     <= six_sh_d;
            ext_sh_q     <= ext_sh_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and counters
    // -----------------------------------------------------------------------
    always_comb begin
        sync1_d      = PAD_IN;
        sync2_d      = sync1_q;
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        settle_cnt_d = settle_cnt_q;
        phase_d      = phase_q;

        case (state_q)
            S_IDLE: begin
                if (CE) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        // Counter saturates here while ENABLE is low.
                        if (ENABLE) begin
                            state_d      = S_PHASE;
                            phase_d      = '0;
                            settle_cnt_d = '0;
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            S_PHASE: begin
                if (CE) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = '0;
                        phase_d      = phase_q + 3'd1;
                        if (phase_q == LAST_PHASE) begin
                            state_d = S_LATCH;
                        end
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end
            end
            S_LATCH: begin
                state_d    = S_IDLE;
                idle_cnt_d = '0;
            end
            default: begin
                state_d    = S_IDLE;
                idle_cnt_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: TH, sampling into shadows, publishing in S_LATCH
    // -----------------------------------------------------------------------
    always_comb begin
        th_d         = th_q;
        valid_d      = 1'b0;
        present_d    = present_q;
        base_d       = base_q;
        base_sh_d    = base_sh_q;
        present_sh_d = present_sh_q;
`ifdef DB9_PAD_SCANNER_SIX_BUTTON_EN
        six_d        = six_q;
        ext_d        = ext_q;
        six_sh_d     = six_sh_q;
        ext_sh_d     = ext_sh_q;
`endif

        case (state_q)
            S_IDLE: begin
                th_d = 1'b1;
            end
            S_PHASE: begin
                if (sample_tick) begin
                    // The next phase drives TH = ~(phase+1)[0] = phase[0].
                    // The last phase is always odd, so this also restores
                    // TH high on the way into S_LATCH.
                    th_d = phase_q[0];
                    case (phase_q)
                        3'd0: begin
                            base_sh_d[3:0] = line_low[3:0];   // U D L R
                            base_sh_d[5]   = line_low[4];     // B
                            base_sh_d[6]   = line_low[5];     // C
                        end
                        3'd1: begin
                            base_sh_d[4]   = line_low[4];     // A
                            base_sh_d[7]   = line_low[5];     // START
                            present_sh_d   = line_low[2] & line_low[3];
                        end
`ifdef DB9_PAD_SCANNER_SIX_BUTTON_EN
                        3'd5: begin
                            six_sh_d = &line_low[3:0];
                        end
                        3'd6: begin
                            // D0..D3 carry Z, Y, X, MODE on this phase.
                            ext_sh_d = {line_low[0], line_low[1], line_low[2], line_low[3]};
                        end
`endif
                        default: begin
                        end
                    endcase
                end
            end
            S_LATCH: begin
                th_d      = 1'b1;
                valid_d   = 1'b1;
                present_d = present_sh_q;
                base_d    = present_sh_q ? base_sh_q : 8'h00;
`ifdef DB9_PAD_SCANNER_SIX_BUTTON_EN
                six_d     = present_sh_q & six_sh_q;
                ext_d     = (present_sh_q && six_sh_q) ? ext_sh_q : 4'h0;
`endif
            end
            default: begin
                th_d = 1'b1;
            end
        endcase
    end

    assign PAD_TH  = th_q;
    assign VALID   = valid_q;
    assign PRESENT = present_q;
    assign {P_START, P_C, P_B, P_A, P_RIGHT, P_LEFT, P_DOWN, P_UP} = base_q;

`ifdef DB9_PAD_SCANNER_SIX_BUTTON_EN
    assign {P_Z, P_Y, P_X, P_MODE} = ext_q;
    assign SIX_BTN = six_q;
`else
    assign {P_Z, P_Y, P_X, P_MODE} = 4'h0;
    assign SIX_BTN = 1'b0;
`endif

endmodule
